// File: rtl/tnet_tx_req.sv
// tnet_tx_req: queues transmit commands and hands them to the link controller
// over a four-phase req/ack handshake. The ack comes from another clock domain
// and is synchronised before the FSM looks at it.
//
// state | meaning
// IDLE  | no packet in flight; pops the queue when it holds an entry
// ACK_H | request raised, waiting for ack high (or the timeout)
// ACK_L | request dropped, waiting for ack low before the next packet
module tnet_tx_req #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [9:0]                  ID,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic [7:0]                  cmd_op_i,
    input  logic [5:0]                  cmd_flags_i,
    input  logic [9:0]                  cmd_dst_i,
    input  logic [19:0]                 cmd_arg_i,
    input  logic [63:0]                 cmd_data_i,
    output logic                        tx_req_o,
    output logic [63:0]                 tx_header_o,
    output logic [63:0]                 tx_data_o,
    input  logic                        tx_ack_i,
    input  logic                        clr_err_i,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o,
    output logic [15:0]                 sent_cnt_o,
    output logic                        err_timeout_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    // Wait counter is just wide enough to reach TIMEOUT.
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [WW-1:0] TO_VAL   = WW'(TIMEOUT);
    localparam bit            TO_EN    = (TIMEOUT > 0);

    typedef struct packed {
        logic [7:0]  op;
        logic [5:0]  flags;
        logic [9:0]  dst;
        logic [19:0] arg;
        logic [63:0] data;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK_H = 2'd1,
        ACK_L = 2'd2
    } state_t;

    cmd_t          mem_q [FIFO_DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push, pop;

    logic          ack_meta_q, ack_s_q;

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic [63:0]   hdr_q, hdr_d;
    logic [63:0]   data_q, data_d;
    logic [WW-1:0] wait_q, wait_d, wait_inc;
    logic [15:0]   sent_q, sent_d;
    logic          err_q, err_d;

    assign cmd_ready_o   = (cnt_q != FULL_CNT);
    assign push          = cmd_valid_i && cmd_ready_o;
    assign pop           = (state_q == IDLE) && (cnt_q != '0);
    assign head          = mem_q[rd_ptr_q];

    assign tx_req_o      = req_q;
    assign tx_header_o   = hdr_q;
    assign tx_data_o     = data_q;
    assign fifo_cnt_o    = cnt_q;
    assign sent_cnt_o    = sent_q;
    assign err_timeout_o = err_q;
    assign busy_o        = (state_q != IDLE) || (cnt_q != '0);

    // Queue pointer and occupancy update; a full queue never accepts, even when popping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (!push && pop) cnt_d = cnt_q - CW'(1);
    end

    // Queue storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{op: cmd_op_i, flags: cmd_flags_i, dst: cmd_dst_i,
                                 arg: cmd_arg_i, data: cmd_data_i};
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Two-flop synchroniser for the link-domain ack.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            ack_meta_q <= tx_ack_i;
            ack_s_q    <= ack_meta_q;
        end
    end

    // Handshake next-state; ack wins over a timeout landing on the same cycle,
    // and a timeout wins over a clear of the sticky error.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        hdr_d    = hdr_q;
        data_d   = data_q;
        wait_d   = wait_q;
        sent_d   = sent_q;
        err_d    = err_q;
        wait_inc = wait_q + WW'(1);
        if (clr_err_i) err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    hdr_d   = {head.op, head.flags, head.dst, ID, 10'd0, head.arg};
                    data_d  = head.data;
                    req_d   = 1'b1;
                    wait_d  = '0;
                    state_d = ACK_H;
                end
            end
            ACK_H: begin
                if (wait_q != '1) wait_d = wait_inc;
                if (ack_s_q) begin
                    req_d   = 1'b0;
                    sent_d  = sent_q + 16'd1;
                    state_d = ACK_L;
                end else if (TO_EN && (wait_q != '1) && (wait_inc == TO_VAL)) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ACK_L;
                end
            end
            ACK_L: begin
                if (!ack_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake state and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            hdr_q   <= '0;
            data_q  <= '0;
            wait_q  <= '0;
            sent_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            hdr_q   <= hdr_d;
            data_q  <= data_d;
            wait_q  <= wait_d;
            sent_q  <= sent_d;
            err_q   <= err_d;
        end
    end

endmodule
